// File: rtl/narrow_link_responder.sv
// narrow_link_responder: far end of the narrow two-phase serial request/response link.
// A wide request arrives as BW_LINK-bit chunks (LSB chunk first) on the forward link. It is
// reassembled and offered to local logic with valid/ready. The local response is then sent
// back chunk by chunk on the backward link. Each chunk is one two-phase toggle/ack exchange.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   link_fwd_in   [BW_LINK] fwd phase, [BW_LINK-1:0] chunk data (bundled with the phase)
//   link_bwd_out  [BW_LINK] bwd phase, [BW_LINK-1:0] response chunk data
//   req_valid/req_ready/req_data   reassembled request towards local logic
//   rsp_valid/rsp_ready/rsp_data   local response (rsp_data ignored when BW_RSP = 0)
//   idle          no transaction in progress
//   txn_count     completed-transaction counter, saturating at 16'hFFFF; present only when
//                 NARROW_LINK_RESPONDER_STAT_EN is defined
module narrow_link_responder #(
  parameter int unsigned BW_REQ     = 32,
  parameter int unsigned BW_RSP     = 32,
  parameter int unsigned BW_LINK    = 8,
  parameter int unsigned SYNC_STAGE = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [BW_LINK:0]                    link_fwd_in,
  output logic [BW_LINK:0]                    link_bwd_out,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [BW_REQ-1:0]                   req_data,
  input  logic                                rsp_valid,
  output logic                                rsp_ready,
  input  logic [(BW_RSP > 0 ? BW_RSP : 1)-1:0] rsp_data,
  output logic                                idle
`ifdef NARROW_LINK_RESPONDER_STAT_EN
  ,
  output logic [15:0]                         txn_count
`endif
);

  localparam int unsigned NReq    = (BW_REQ + BW_LINK - 1) / BW_LINK;
  localparam int unsigned NRsp    = (BW_RSP + BW_LINK - 1) / BW_LINK;
  // Keeps response storage non-empty in the response-less build; those states are unreachable.
  localparam int unsigned NRspEff = (NRsp > 0) ? NRsp : 1;
  localparam int unsigned NMax    = (NReq > NRspEff) ? NReq : NRspEff;
  localparam int unsigned CntW    = (NMax > 1) ? $clog2(NMax) : 1;
  localparam int unsigned RspPadW = NRspEff * BW_LINK;

  localparam logic [CntW-1:0] ReqLast = CntW'(NReq - 1);
  localparam logic [CntW-1:0] RspLast = CntW'(NRspEff - 1);

  typedef enum logic [2:0] {StRx, StIssue, StWaitRsp, StLaunch, StTxWait} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 bwd_phase_q, bwd_phase_d;
  logic [BW_LINK-1:0]   bwd_data_q, bwd_data_d;
  logic [BW_REQ-1:0]    req_q, req_d;
  logic [RspPadW-1:0]   rsp_q, rsp_d;
  logic [SYNC_STAGE-1:0] sync_q;
  logic                 fwd_s;

  // Only the phase bit is synchronized; data is held stable by the sender until acked.
  assign fwd_s = sync_q[SYNC_STAGE-1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRx;
      cnt_q       <= '0;
      bwd_phase_q <= 1'b0;
      bwd_data_q  <= '0;
      req_q       <= '0;
      rsp_q       <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bwd_phase_q <= bwd_phase_d;
      bwd_data_q  <= bwd_data_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      sync_q      <= {sync_q[SYNC_STAGE-2:0], link_fwd_in[BW_LINK]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bwd_phase_d = bwd_phase_q;
    bwd_data_d  = bwd_data_q;
    req_d       = req_q;
    rsp_d       = rsp_q;
    unique case (state_q)
      StRx: begin
        if (fwd_s != bwd_phase_q) begin
          // Bits above BW_REQ in the last chunk have no slot and are dropped.
          for (int i = 0; i < BW_REQ; i++) begin
            if (cnt_q == CntW'(i / BW_LINK)) req_d[i] = link_fwd_in[i % BW_LINK];
          end
          bwd_phase_d = fwd_s;
          if (cnt_q == ReqLast) begin
            state_d = StIssue;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StIssue: begin
        if (req_ready) state_d = (BW_RSP != 0) ? StWaitRsp : StRx;
      end
      StWaitRsp: begin
        if (rsp_valid) begin
          rsp_d      = RspPadW'(rsp_data);
          bwd_data_d = rsp_d[BW_LINK-1:0];
          state_d    = StLaunch;
        end
      end
      // Data was loaded a cycle earlier, so it is stable before the phase edge.
      StLaunch: begin
        bwd_phase_d = ~bwd_phase_q;
        state_d     = StTxWait;
      end
      StTxWait: begin
        if (fwd_s == bwd_phase_q) begin
          if (cnt_q == RspLast) begin
            state_d = StRx;
            cnt_d   = '0;
          end else begin
            cnt_d      = cnt_q + CntW'(1);
            bwd_data_d = rsp_q[cnt_d*BW_LINK +: BW_LINK];
            state_d    = StLaunch;
          end
        end
      end
      default: state_d = StRx;
    endcase
  end

  // Outputs
  always_comb begin
    req_valid    = (state_q == StIssue);
    rsp_ready    = (state_q == StWaitRsp);
    idle         = (state_q == StRx) && (cnt_q == '0);
    req_data     = req_q;
    link_bwd_out = {bwd_phase_q, bwd_data_q};
  end

`ifdef NARROW_LINK_RESPONDER_STAT_EN
  logic        txn_done;
  logic [15:0] txn_count_q;

  always_comb begin
    txn_done = ((state_q == StIssue) && req_ready && (BW_RSP == 0)) ||
               ((state_q == StTxWait) && (fwd_s == bwd_phase_q) && (cnt_q == RspLast));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= '0;
    end else if (txn_done && (txn_count_q != 16'hFFFF)) begin
      txn_count_q <= txn_count_q + 16'd1;
    end
  end

  assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_narrow_link_responder.sv
// Self-checking bench: three responders (32/32 sync2, 20/12 sync3, 16/0 sync2) driven by a
// behavioural initiator; expectations come from plain arithmetic on the transaction values.
module tb_narrow_link_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [8:0]  fwd0 = '0, fwd1 = '0, fwd2 = '0;
  logic [8:0]  bwd0, bwd1, bwd2;
  logic [2:0]  req_ready = '0, rsp_valid = '0;
  logic [2:0]  req_valid, rsp_ready, idle;
  logic [31:0] req_data0;
  logic [19:0] req_data1;
  logic [15:0] req_data2;
  logic [31:0] rsp_data0 = '0;
  logic [11:0] rsp_data1 = '0;
  logic [0:0]  rsp_data2 = '0;
`ifdef NARROW_LINK_RESPONDER_STAT_EN
  logic [15:0] txn0, txn1, txn2;
`endif

  int checks = 0;
  int errors = 0;
  int n_txn0 = 0;

  narrow_link_responder #(.BW_REQ(32), .BW_RSP(32), .BW_LINK(8), .SYNC_STAGE(2)) u_dut0 (
    .clk(clk), .rst(rst), .link_fwd_in(fwd0), .link_bwd_out(bwd0),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_data(req_data0),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data0), .idle(idle[0])
`ifdef NARROW_LINK_RESPONDER_STAT_EN
    , .txn_count(txn0)
`endif
  );

  narrow_link_responder #(.BW_REQ(20), .BW_RSP(12), .BW_LINK(8), .SYNC_STAGE(3)) u_dut1 (
    .clk(clk), .rst(rst), .link_fwd_in(fwd1), .link_bwd_out(bwd1),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_data(req_data1),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data1), .idle(idle[1])
`ifdef NARROW_LINK_RESPONDER_STAT_EN
    , .txn_count(txn1)
`endif
  );

  narrow_link_responder #(.BW_REQ(16), .BW_RSP(0), .BW_LINK(8), .SYNC_STAGE(2)) u_dut2 (
    .clk(clk), .rst(rst), .link_fwd_in(fwd2), .link_bwd_out(bwd2),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_data(req_data2),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data2), .idle(idle[2])
`ifdef NARROW_LINK_RESPONDER_STAT_EN
    , .txn_count(txn2)
`endif
  );

  // ---------------- per-instance configuration and access ----------------
  function automatic int req_w(int d);
    case (d) 0: return 32; 1: return 20; default: return 16; endcase
  endfunction
  function automatic int rsp_w(int d);
    case (d) 0: return 32; 1: return 12; default: return 0; endcase
  endfunction
  function automatic int sync_n(int d);
    return (d == 1) ? 3 : 2;
  endfunction
  function automatic logic [31:0] mask_w(int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction
  function automatic logic [8:0] get_bwd(int d);
    case (d) 0: return bwd0; 1: return bwd1; default: return bwd2; endcase
  endfunction
  function automatic logic [8:0] get_fwd(int d);
    case (d) 0: return fwd0; 1: return fwd1; default: return fwd2; endcase
  endfunction
  function automatic logic [31:0] get_rd(int d);
    case (d) 0: return req_data0; 1: return 32'(req_data1); default: return 32'(req_data2);
    endcase
  endfunction

  task automatic set_fwd(int d, logic [8:0] v);
    case (d) 0: fwd0 = v; 1: fwd1 = v; default: fwd2 = v; endcase
  endtask
  task automatic set_rsp(int d, logic [31:0] v);
    case (d) 0: rsp_data0 = v; 1: rsp_data1 = v[11:0]; default: rsp_data2 = v[0]; endcase
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- initiator model ----------------
  task automatic send_chunk(int d, logic [7:0] c, bit chk_lat);
    logic p;
    int   n;
    p = ~get_fwd(d)[8];
    set_fwd(d, {p, c});
    n = 0;
    while (1) begin
      tick();
      n++;
      if (get_bwd(d)[8] == p || n >= 20) break;
    end
    checks++;
    if (get_bwd(d)[8] !== p) begin
      errors++;
      $display("FAIL req_ack dut%0d: bwd phase %b, required %b", d, get_bwd(d)[8], p);
    end else if (chk_lat) begin
      checks++;
      if (n !== sync_n(d) + 1) begin
        errors++;
        $display("FAIL ack_latency dut%0d: %0d edges, required %0d", d, n, sync_n(d) + 1);
      end
    end
  endtask

  task automatic send_request(int d, logic [31:0] data);
    int nch;
    logic [31:0] sh;
    nch = (req_w(d) + 7) / 8;
    for (int k = 0; k < nch; k++) begin
      sh = data >> (8 * k);
      send_chunk(d, sh[7:0], 1'b1);
    end
    checks++;
    if (req_valid[d] !== 1'b1) begin
      errors++;
      $display("FAIL req_valid_rise dut%0d: %b, required 1", d, req_valid[d]);
    end
  endtask

  task automatic accept_request(int d, logic [31:0] data, int hold);
    logic [31:0] exp;
    exp = data & mask_w(req_w(d));
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (req_valid[d] !== 1'b1 || get_rd(d) !== exp) begin
        errors++;
        $display("FAIL req_hold dut%0d: valid %b data %h, required 1 %h", d, req_valid[d],
                 get_rd(d), exp);
      end
      if (i < hold) tick();
    end
    req_ready[d] = 1'b1;
    tick();
    req_ready[d] = 1'b0;
    checks++;
    if (req_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL req_valid_drop dut%0d: %b, required 0", d, req_valid[d]);
    end
  endtask

  task automatic wait_bwd_toggle(int d);
    int n;
    n = 0;
    while (get_bwd(d)[8] == get_fwd(d)[8] && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_response(int d, logic [31:0] rsp);
    int nch;
    int h;
    logic [31:0] rm, sh;
    nch = (rsp_w(d) + 7) / 8;
    rm = rsp & mask_w(rsp_w(d));
    checks++;
    if (rsp_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL rsp_ready dut%0d: %b, required 1", d, rsp_ready[d]);
    end
    set_rsp(d, rsp);
    rsp_valid[d] = 1'b1;
    tick();
    rsp_valid[d] = 1'b0;
    checks++;
    if (rsp_ready[d] !== 1'b0) begin
      errors++;
      $display("FAIL rsp_ready_drop dut%0d: %b, required 0", d, rsp_ready[d]);
    end
    for (int k = 0; k < nch; k++) begin
      sh = rm >> (8 * k);
      wait_bwd_toggle(d);
      checks++;
      if (get_bwd(d)[8] === get_fwd(d)[8] || get_bwd(d)[7:0] !== sh[7:0]) begin
        errors++;
        $display("FAIL rsp_chunk%0d dut%0d: phase %b data %h, required toggled %h", k, d,
                 get_bwd(d)[8], get_bwd(d)[7:0], sh[7:0]);
      end
      h = $urandom_range(0, 3);
      for (int i = 0; i < h; i++) begin
        tick();
        checks++;
        if (get_bwd(d)[8] === get_fwd(d)[8] || get_bwd(d)[7:0] !== sh[7:0]) begin
          errors++;
          $display("FAIL rsp_unacked_hold dut%0d: bwd %h, required stable", d, get_bwd(d));
        end
      end
      set_fwd(d, {get_bwd(d)[8], get_fwd(d)[7:0]});
    end
    h = 0;
    while (idle[d] !== 1'b1 && h < 20) begin
      tick();
      h++;
    end
    checks++;
    if (idle[d] !== 1'b1 || get_bwd(d)[8] !== get_fwd(d)[8]) begin
      errors++;
      $display("FAIL rsp_done_idle dut%0d: idle %b, required 1", d, idle[d]);
    end
    if (d == 0) n_txn0++;
  endtask

  task automatic check_reset_outputs(string tag);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (get_bwd(d) !== 9'h0 || req_valid[d] !== 1'b0 || rsp_ready[d] !== 1'b0 ||
          idle[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s dut%0d: bwd %h rv %b rr %b idle %b, required 000 0 0 1", tag, d,
                 get_bwd(d), req_valid[d], rsp_ready[d], idle[d]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reassembly();
    send_request(0, 32'h12345678);
    accept_request(0, 32'h12345678, 5);
    do_response(0, 32'hCAFEBABE);
  endtask

  task automatic test_random();
    logic [31:0] a, r;
    for (int t = 0; t < 4; t++) begin
      a = $urandom;
      r = $urandom;
      send_request(0, a);
      accept_request(0, a, $urandom_range(0, 4));
      do_response(0, r);
    end
  endtask

  task automatic test_padding();
    logic [31:0] a;
    send_request(1, 32'h00F54321);
    accept_request(1, 32'h00F54321, 2);
    do_response(1, 32'h00000ABC);
    a = $urandom;
    send_request(1, a);
    accept_request(1, a, 1);
    do_response(1, $urandom);
  endtask

  task automatic test_no_response();
    logic [31:0] a;
    a = $urandom;
    send_request(2, a);
    accept_request(2, a, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (idle[2] !== 1'b1 || get_bwd(2)[8] !== get_fwd(2)[8]) begin
        errors++;
        $display("FAIL norsp_quiet: idle %b bwd %h, required idle and no toggle", idle[2],
                 get_bwd(2));
      end
      tick();
    end
  endtask

  // Second request's first chunk is toggled while the first is still waiting for req_ready.
  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic p;
    int n;
    a = $urandom;
    b = $urandom;
    send_request(2, a);
    p = ~get_fwd(2)[8];
    set_fwd(2, {p, b[7:0]});
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (get_bwd(2)[8] === p || get_rd(2) !== (a & 32'hFFFF)) begin
        errors++;
        $display("FAIL b2b_no_ack_in_issue: bwd %h data %h, required no ack, data %h",
                 get_bwd(2), get_rd(2), a & 32'hFFFF);
      end
    end
    accept_request(2, a, 0);
    n = 0;
    while (get_bwd(2)[8] != p && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (get_bwd(2)[8] !== p) begin
      errors++;
      $display("FAIL b2b_late_ack: bwd phase %b, required %b", get_bwd(2)[8], p);
    end
    send_chunk(2, b[15:8], 1'b1);
    checks++;
    if (req_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_valid: %b, required 1", req_valid[2]);
    end
    accept_request(2, b, 1);
  endtask

  task automatic test_abort();
    logic [31:0] a;
    send_request(0, 32'hA5A55A5A);
    accept_request(0, 32'hA5A55A5A, 0);
    set_rsp(0, 32'h01020304);
    rsp_valid[0] = 1'b1;
    tick();
    rsp_valid[0] = 1'b0;
    wait_bwd_toggle(0);
    #2;
    rst = 1'b1;
    fwd0 = '0;
    fwd1 = '0;
    fwd2 = '0;
    #1 check_reset_outputs("abort_reset");
    n_txn0 = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    a = $urandom;
    send_request(0, a);
    accept_request(0, a, 1);
    do_response(0, 32'h89ABCDEF);
  endtask

  task automatic test_stats();
    logic [31:0] a;
    for (int t = 0; t < 2; t++) begin
      a = $urandom;
      send_request(0, a);
      accept_request(0, a, 0);
      do_response(0, $urandom);
    end
`ifdef NARROW_LINK_RESPONDER_STAT_EN
    checks++;
    if (txn0 !== 16'(n_txn0)) begin
      errors++;
      $display("FAIL txn_count: %0d, required %0d", txn0, n_txn0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reassembly();
    test_random();
    test_padding();
    test_no_response();
    test_back_to_back();
    test_abort();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
